// File: rtl/result_bcd_if.sv
// Result-to-display handshake bundle between the ALU result producer and the
// BCD decoder.
//
// Handshake: the producer drives result/ovf_in and raises convertstrobe. The
// decoder accepts the request on a rising edge only while idle (busy=0).
// Strobes seen while busy are dropped, not queued. busy stays high from the
// accept edge until done is asserted. done is a one-cycle pulse that marks
// digits/negative/rangeerr/ovf_out as new. Those outputs hold between pulses.
//
// Signals:
//   result        producer -> decoder  signed value to convert
//   ovf_in        producer -> decoder  ALU overflow flag, sampled with result
//   convertstrobe producer -> decoder  start request
//   busy          decoder -> producer  conversion in progress
//   done          decoder -> producer  one-cycle "outputs updated" pulse
//   digits        decoder -> producer  packed BCD, units in [3:0]
//   negative      decoder -> producer  converted value was negative
//   rangeerr      decoder -> producer  magnitude did not fit in DIGITS digits
//   ovf_out       decoder -> producer  ovf_in captured with the accepted request
interface result_bcd_if #(
  parameter int BITS   = 21,
  parameter int DIGITS = 6
);
  logic [BITS-1:0]     result;
  logic                ovf_in;
  logic                convertstrobe;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] digits;
  logic                negative;
  logic                rangeerr;
  logic                ovf_out;

  modport master (
    output result, ovf_in, convertstrobe,
    input  busy, done, digits, negative, rangeerr, ovf_out
  );

  modport slave (
    input  result, ovf_in, convertstrobe,
    output busy, done, digits, negative, rangeerr, ovf_out
  );
endinterface

// File: rtl/result_bcd_decoder.sv
// Sequential binary-to-BCD converter for the 7-segment display path.
// Takes a signed BITS-wide ALU result and converts its magnitude to DIGITS
// packed BCD digits with the shift-add-3 (double dabble) method, one bit per
// clock.
//
// Ports:
//   clock      system clock, rising-edge
//   reset      synchronous, active-high; aborts any conversion
//   bus        result_bcd_if slave modport (request in, digits/status out)
//   dbg_state  current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
//
// Timing: strobe accepted at edge N, done is high in the cycle after edge
// N+BITS+1.
module result_bcd_decoder #(
  parameter int BITS   = 21,
  parameter int DIGITS = 6
) (
  input  logic         clock,
  input  logic         reset,
  result_bcd_if.slave  bus,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(BITS + 1);
  // One spare digit so the accumulator cannot overflow on out-of-range input.
  localparam int AW = 4 * (DIGITS + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_MAG = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BITS-1:0]     shift_q;
  logic [AW-1:0]       acc_q;
  logic [CW-1:0]       cnt_q;
  logic                neg_q;
  logic                ovf_q;
  logic                rerr_q;

  logic [4*DIGITS-1:0] digits_q;
  logic                negative_q;
  logic                rangeerr_q;
  logic                ovf_out_q;
  logic                done_q;

  logic [BITS-1:0]     abs_in;
  logic                range_err_in;
  logic [AW-1:0]       acc_adj;
  logic [AW-1:0]       acc_next;
  logic [BITS-1:0]     shift_next;

  // Magnitude in BITS unsigned bits: the most negative input maps to
  // 2^(BITS-1), which still fits because the result is treated as unsigned.
  always_comb begin
    abs_in       = bus.result[BITS-1] ? (~bus.result + 1'b1) : bus.result;
    range_err_in = {{(64-BITS){1'b0}}, abs_in} > MAX_MAG;
  end

  // Add 3 to every digit >= 5 before the shift, then shift {acc, mag} left.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    {acc_next, shift_next} = {acc_adj, shift_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.convertstrobe) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1))   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rerr_q     <= 1'b0;
      digits_q   <= '0;
      negative_q <= 1'b0;
      rangeerr_q <= 1'b0;
      ovf_out_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.convertstrobe) begin
            shift_q <= abs_in;
            acc_q   <= '0;
            cnt_q   <= CW'(BITS);
            // Sign bit alone: zero can never come out as negative.
            neg_q   <= bus.result[BITS-1];
            ovf_q   <= bus.ovf_in;
            rerr_q  <= range_err_in;
          end
        end
        SHIFT: begin
          acc_q   <= acc_next;
          shift_q <= shift_next;
          cnt_q   <= cnt_q - CW'(1);
        end
        DONE: begin
          // Out-of-range values show the blank code on every digit.
          digits_q   <= rerr_q ? '1 : acc_q[4*DIGITS-1:0];
          negative_q <= neg_q;
          rangeerr_q <= rerr_q;
          ovf_out_q  <= ovf_q;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.digits   = digits_q;
  assign bus.negative = negative_q;
  assign bus.rangeerr = rangeerr_q;
  assign bus.ovf_out  = ovf_out_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_result_bcd_decoder.sv
module tb_result_bcd_decoder;
  localparam int BITS   = 21;
  localparam int DIGITS = 6;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  result_bcd_if #(.BITS(BITS), .DIGITS(DIGITS)) bus ();

  result_bcd_decoder #(.BITS(BITS), .DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int tests = 0;
  int fails = 0;
  logic [4*DIGITS-1:0] exp_q[$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint ref_mag(input int v);
    return (v < 0) ? -longint'(v) : longint'(v);
  endfunction

  function automatic logic [4*DIGITS-1:0] ref_digits(input int v);
    longint m;
    logic [4*DIGITS-1:0] d;
    m = ref_mag(v);
    d = '0;
    if (m > 999999) return '1;
    for (int i = 0; i < DIGITS; i++) begin
      d[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return d;
  endfunction

  // ---------------- driver ----------------
  task automatic run_conv(input int val, input logic ovf);
    int   lat;
    logic busy_bad;
    logic busy_at_done;
    logic [4*DIGITS-1:0] exp_d;
    logic [4*DIGITS-1:0] held;
    exp_q.push_back(ref_digits(val));
    @(negedge clock);
    bus.result        = BITS'(val);
    bus.ovf_in        = ovf;
    bus.convertstrobe = 1'b1;
    @(negedge clock);               // accept edge N has passed
    bus.convertstrobe = 1'b0;
    lat          = 0;
    busy_bad     = 1'b0;
    busy_at_done = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (bus.done) begin
        lat          = k;
        busy_at_done = bus.busy;
        break;
      end
      if (!bus.busy) busy_bad = 1'b1;
    end
    exp_d = exp_q.pop_front();
    check("latency",      64'(lat), 64'd22);
    check("busy_during",  64'(busy_bad), 64'd0);
    check("busy_at_done", 64'(busy_at_done), 64'd0);
    check("digits",       64'(bus.digits), 64'(exp_d));
    check("negative",     64'(bus.negative), 64'(val < 0));
    check("rangeerr",     64'(bus.rangeerr), 64'(ref_mag(val) > 999999));
    check("ovf_out",      64'(bus.ovf_out), 64'(ovf));
    held = bus.digits;
    @(negedge clock);
    check("done_pulse",   64'(bus.done), 64'd0);
    check("digits_hold",  64'(bus.digits), 64'(held));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ndone;
    int k1, k2;
    logic [4*DIGITS-1:0] first_d;

    bus.result        = '0;
    bus.ovf_in        = 1'b0;
    bus.convertstrobe = 1'b0;
    reset             = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_busy",     64'(bus.busy), 64'd0);
    check("rst_done",     64'(bus.done), 64'd0);
    check("rst_digits",   64'(bus.digits), 64'd0);
    check("rst_negative", 64'(bus.negative), 64'd0);
    check("rst_rangeerr", 64'(bus.rangeerr), 64'd0);
    check("rst_ovf_out",  64'(bus.ovf_out), 64'd0);

    // directed values
    run_conv(998001, 1'b0);
    run_conv(-998001, 1'b1);
    run_conv(0, 1'b0);
    run_conv(999999, 1'b0);
    run_conv(1000000, 1'b0);
    run_conv(-1048576, 1'b0);
    run_conv(-1, 1'b1);

    // strobe during busy is dropped
    @(negedge clock);
    bus.result = BITS'(12); bus.ovf_in = 1'b0; bus.convertstrobe = 1'b1;
    @(negedge clock);
    bus.convertstrobe = 1'b0;
    repeat (2) @(negedge clock);
    bus.result = BITS'(34); bus.convertstrobe = 1'b1;
    @(negedge clock);
    bus.convertstrobe = 1'b0;
    ndone   = 0;
    first_d = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (bus.done) begin
        if (ndone == 0) first_d = bus.digits;
        ndone++;
      end
    end
    check("busy_strobe_ndone",  64'(ndone), 64'd1);
    check("busy_strobe_digits", 64'(first_d), 64'(ref_digits(12)));

    // reset mid-conversion
    @(negedge clock);
    bus.result = BITS'(777); bus.convertstrobe = 1'b1;
    @(negedge clock);
    bus.convertstrobe = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy",     64'(bus.busy), 64'd0);
    check("abort_digits",   64'(bus.digits), 64'd0);
    check("abort_negative", 64'(bus.negative), 64'd0);
    check("abort_rangeerr", 64'(bus.rangeerr), 64'd0);
    check("abort_ovf_out",  64'(bus.ovf_out), 64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    run_conv(42, 1'b0);

    // strobe held high: re-accepted right after the done cycle
    @(negedge clock);
    bus.result = BITS'(5); bus.convertstrobe = 1'b1;
    k1 = -1;
    k2 = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (bus.done) begin
        if (k1 < 0) begin
          k1 = k;
          check("held_digits1", 64'(bus.digits), 64'(ref_digits(5)));
        end else begin
          k2 = k;
          bus.convertstrobe = 1'b0;
          check("held_digits2", 64'(bus.digits), 64'(ref_digits(5)));
          break;
        end
      end
    end
    bus.convertstrobe = 1'b0;
    check("held_spacing", 64'(k2 - k1), 64'd23);
    repeat (30) @(negedge clock);

    // randomized values against the model
    for (int i = 0; i < 40; i++) begin
      int v;
      if ($urandom_range(0, 1) == 0) begin
        v = int'($urandom_range(0, 999999));
        if ($urandom_range(0, 1) == 1) v = -v;
      end else begin
        v = int'($urandom_range(0, (1 << BITS) - 1));
        if (v >= (1 << (BITS - 1))) v = v - (1 << BITS);
      end
      run_conv(v, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
